// File: rtl/cordic_pkg.sv
// Shared CORDIC constants, mode encodings and the demodulator FSM state type.
package cordic_pkg;

  localparam int unsigned CORDIC_GAIN_COMP = 19898;
  localparam int unsigned PHASE_W          = 16;

  localparam logic MODE_VECTOR = 1'b0;
  localparam logic MODE_ROTATE = 1'b1;

  typedef enum logic [0:0] {
    StPrime,
    StRun
  } demod_st_e;

  // Removes the CORDIC gain (about 1.647) from a vectoring magnitude; negative input reads as 0.
  function automatic logic [15:0] gain_comp(input logic [15:0] x);
    logic [14:0] xp;
    logic [29:0] prod;
    xp   = x[15] ? 15'd0 : x[14:0];
    prod = 30'(xp) * 30'(CORDIC_GAIN_COMP);
    return prod[30-1:15] == 15'd0 ? 16'd0 : {1'b0, prod[29:15]};
  endfunction

endpackage

// File: rtl/dc_block16.sv
// Leaky-integrator DC blocker: am = mag - (acc >>> DCSHIFT), saturated to 16 bits signed.
module dc_block16 #(
  parameter int unsigned DCSHIFT = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               oe,
  input  logic [15:0]        mag,
  output logic signed [15:0] am,
  output logic               sat
);

  localparam int unsigned AW = 16 + DCSHIFT;

  logic signed [AW-1:0] acc_q, acc_d, avg;
  logic signed [AW:0]   diff;
  logic [AW-15:0]       top_bits;
  logic [15:0]          am_q, am_d;
  logic                 sat_q, sat_d;

  assign avg = acc_q >>> DCSHIFT;

  always_comb begin
    diff     = signed'({{(AW-15){1'b0}}, mag}) - signed'({avg[AW-1], avg});
    top_bits = diff[AW:15];
    am_d     = diff[15:0];
    sat_d    = 1'b0;
    if (!((top_bits == '0) || (top_bits == '1))) begin
      am_d  = diff[AW] ? 16'h8000 : 16'h7fff;
      sat_d = 1'b1;
    end
    // The accumulator integrates the unsaturated difference.
    acc_d = acc_q + signed'(diff[AW-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      am_q  <= '0;
      sat_q <= 1'b0;
    end else begin
      if (en) acc_q <= acc_d;
      if (oe) begin
        am_q  <= am_d;
        sat_q <= sat_d;
      end
    end
  end

  assign am  = am_q;
  assign sat = sat_q;

endmodule

// File: rtl/cordic_demod16.sv
// AM/FM demodulator back end for a vectoring CORDIC; two-cycle pipeline.
// Optional fm squelch is enabled by defining CORDIC_DEMOD_SQUELCH_EN.
module cordic_demod16
  import cordic_pkg::*;
#(
  parameter int unsigned DCSHIFT    = 10,
  parameter int unsigned SQL_THRESH = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        xi,
  input  logic [15:0]        zi,
  input  logic               rdy,
  input  logic               mi,
  output logic signed [15:0] am,
  output logic signed [15:0] fm,
  output logic               vld,
  output logic               sat
);

  demod_st_e state_q, state_d;

  logic               accept, oe0;
  logic [15:0]        mag0;
  logic [PHASE_W-1:0] fm0, fm0_sq;
  logic [PHASE_W-1:0] zprev_q;

  logic               s1_en_q, s1_oe_q;
  logic [15:0]        s1_mag_q;
  logic [PHASE_W-1:0] s1_fm_q;
  logic [PHASE_W-1:0] fm_q;
  logic               vld_q;

  assign accept = rdy && (mi == MODE_VECTOR);
  assign mag0   = gain_comp(xi);
  assign fm0    = zi - zprev_q;

`ifdef CORDIC_DEMOD_SQUELCH_EN
  assign fm0_sq = (mag0 < 16'(SQL_THRESH)) ? '0 : fm0;
`else
  logic unused_sql_thresh;
  assign unused_sql_thresh = ^SQL_THRESH;
  assign fm0_sq = fm0;
`endif

  always_comb begin
    state_d = state_q;
    oe0     = 1'b0;
    case (state_q)
      StPrime: if (accept) state_d = StRun;
      StRun:   oe0 = accept;
      default: state_d = StPrime;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StPrime;
      zprev_q  <= '0;
      s1_en_q  <= 1'b0;
      s1_oe_q  <= 1'b0;
      s1_mag_q <= '0;
      s1_fm_q  <= '0;
      fm_q     <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_en_q <= accept;
      s1_oe_q <= oe0;
      vld_q   <= s1_oe_q;
      if (accept) begin
        zprev_q  <= zi;
        s1_mag_q <= mag0;
        s1_fm_q  <= fm0_sq;
      end
      if (s1_oe_q) fm_q <= s1_fm_q;
    end
  end

  // Primed samples still update the accumulator, they just never reach the outputs.
  dc_block16 #(
    .DCSHIFT(DCSHIFT)
  ) u_dc_block (
    .clk(clk),
    .rst(rst),
    .en (s1_en_q),
    .oe (s1_oe_q),
    .mag(s1_mag_q),
    .am (am),
    .sat(sat)
  );

  assign fm  = fm_q;
  assign vld = vld_q;

endmodule

// File: tb/tb_cordic_demod16.sv
// Self-checking bench for cordic_demod16 against a queue-based arithmetic reference model.
module tb_cordic_demod16;

  localparam int DCS = 10;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [15:0]        xi = '0;
  logic [15:0]        zi = '0;
  logic               rdy = 1'b0;
  logic               mi = 1'b0;
  logic signed [15:0] am, fm;
  logic               vld, sat;

  cordic_demod16 dut (
    .clk(clk),
    .rst(rst),
    .xi (xi),
    .zi (zi),
    .rdy(rdy),
    .mi (mi),
    .am (am),
    .fm (fm),
    .vld(vld),
    .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] am;
    logic [15:0] fm;
    logic        sat;
  } exp_t;

  exp_t        q[$];
  longint      acc_m;
  logic [15:0] zprev_m;
  bit          run_m;
  logic [15:0] am_h, fm_h;
  logic        sat_h;
  int          cyc, nchk, nfail, nvld;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_accept(input logic [15:0] x, input logic [15:0] z);
    int          xp, mag;
    longint      avg, diff;
    exp_t        e;
    logic [15:0] fmv;
    xp   = x[15] ? 0 : int'(x);
    mag  = (xp * 19898) / 32768;
    avg  = acc_m >>> DCS;
    diff = longint'(mag) - avg;
    e.cyc = cyc + 2;
    e.sat = 1'b0;
    if (diff > 32767) begin
      e.am = 16'h7fff; e.sat = 1'b1;
    end else if (diff < -32768) begin
      e.am = 16'h8000; e.sat = 1'b1;
    end else begin
      e.am = 16'(diff);
    end
    acc_m = acc_m + diff;
    fmv   = z - zprev_m;
`ifdef CORDIC_DEMOD_SQUELCH_EN
    if (mag < 256) fmv = 16'd0;
`endif
    e.fm    = fmv;
    zprev_m = z;
    if (run_m) q.push_back(e);
    else run_m = 1'b1;
  endtask

  task automatic tick(input bit rs, input bit r, input bit m, input logic [15:0] x,
                      input logic [15:0] z);
    bit   expv;
    exp_t e;
    rst = rs; rdy = r; mi = m; xi = x; zi = z;
    if (rs) begin
      q.delete();
      acc_m = 0; zprev_m = '0; run_m = 1'b0;
      am_h = '0; fm_h = '0; sat_h = 1'b0;
    end else if (r && !m) begin
      model_accept(x, z);
    end
    @(posedge clk);
    #1;
    cyc++;
    expv = (q.size() > 0) && (q[0].cyc == cyc);
    chk("vld", {15'd0, vld}, {15'd0, expv});
    if (expv) begin
      e = q.pop_front();
      am_h = e.am; fm_h = e.fm; sat_h = e.sat;
      nvld++;
    end
    chk("am", am, am_h);
    chk("fm", fm, fm_h);
    chk("sat", {15'd0, sat}, {15'd0, sat_h});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
  endtask

  task automatic smp(input logic [15:0] x, input logic [15:0] z);
    tick(1'b0, 1'b1, 1'b0, x, z);
  endtask

  task automatic do_rst();
    tick(1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
  endtask

  initial begin
    int n0;
    cyc = 0; nchk = 0; nfail = 0; nvld = 0;
    acc_m = 0; zprev_m = '0; run_m = 1'b0; am_h = '0; fm_h = '0; sat_h = 1'b0;

    // Reset, then a single primed sample produces nothing.
    do_rst();
    do_rst();
    n0 = nvld;
    smp(16'd16470, 16'd1234);
    idle(4);
    chk("prime_no_vld", 16'(nvld - n0), 16'd0);

    // Phase wrap, including 49152 -> 0.
    do_rst();
    n0 = nvld;
    smp(16'd16470, 16'd0);
    smp(16'd16470, 16'd16384);
    smp(16'd16470, 16'd32768);
    smp(16'd16470, 16'd49152);
    smp(16'd16470, 16'd0);
    idle(3);
    chk("wrap_count", 16'(nvld - n0), 16'd4);
    chk("wrap_fm", fm, 16'h4000);

    // Negative step and mode filtering.
    do_rst();
    smp(16'd16470, 16'd0);
    smp(16'd16470, 16'd49152);
    idle(3);
    chk("neg_fm", fm, 16'hc000);
    n0 = nvld;
    tick(1'b0, 1'b1, 1'b1, 16'd16470, 16'd5);
    idle(3);
    chk("rotate_ignored", 16'(nvld - n0), 16'd0);
    smp(16'd16470, 16'd49152);
    idle(3);
    chk("same_phase_fm", fm, 16'h0000);

    // AM path: first output after priming, decay, negative magnitude.
    do_rst();
    smp(16'd16470, 16'd0);
    smp(16'd16470, 16'd0);
    idle(3);
    chk("am_first", am, 16'd9992);
    for (int i = 0; i < 30; i++) smp(16'd16470, 16'd0);
    smp(16'hfffb, 16'd0);
    idle(3);

    // Throughput: eight back-to-back samples give seven outputs.
    do_rst();
    n0 = nvld;
    for (int i = 0; i < 8; i++) smp(16'($urandom), 16'($urandom));
    idle(3);
    chk("burst_count", 16'(nvld - n0), 16'd7);
    for (int i = 0; i < 4; i++) smp(16'($urandom), 16'($urandom));
    do_rst();
    chk("rst_vld", {15'd0, vld}, 16'd0);
    idle(3);

    // Small magnitude, phase stepping by 1000.
    do_rst();
    for (int i = 0; i < 4; i++) smp(16'd200, 16'(i * 1000));
    idle(3);
`ifdef CORDIC_DEMOD_SQUELCH_EN
    chk("squelch_fm", fm, 16'd0);
`else
    chk("squelch_fm", fm, 16'd1000);
`endif

    // Randomized traffic with occasional resets and rotation-mode strobes.
    do_rst();
    for (int i = 0; i < 400; i++) begin
      bit rs, r, m;
      rs = ($urandom_range(99) < 2);
      r  = ($urandom_range(99) < 70);
      m  = ($urandom_range(99) < 20);
      tick(rs, r, m, 16'($urandom), 16'($urandom));
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
